// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the MiniMIPS32 pipeline control unit: reset/stop
// polarities and the default parameter values of pipe_ctrl.
package pipe_ctrl_pkg;

    localparam logic RstEnable = 1'b0;
    localparam logic Stop      = 1'b1;

    localparam int DEF_NSTAGE     = 6;
    localparam int DEF_FLUSH_HOLD = 2;
    localparam int DEF_PC_W       = 32;
    localparam int DEF_WDOG_W     = 16;
    localparam int DEF_WDOG_LIMIT = 4096;
    localparam int STALL_CNT_W    = 32;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages / exception unit (master) and the
// pipeline control unit (slave).
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int PC_W   = DEF_PC_W
);
    logic [NSTAGE-1:0]      stop_req;
    logic                   flush_req;
    logic [PC_W-1:0]        flush_pc;
    logic                   wdog_clr;
    logic [NSTAGE-1:0]      stall;
    logic                   flush_o;
    logic [PC_W-1:0]        flush_pc_o;
    logic                   wdog_timeout;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output stop_req, flush_req, flush_pc, wdog_clr,
        input  stall, flush_o, flush_pc_o, wdog_timeout, stall_cycles
    );

    modport slave (
        input  stop_req, flush_req, flush_pc, wdog_clr,
        output stall, flush_o, flush_pc_o, wdog_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_stall_thermo.sv
// Priority-to-thermometer encoder: the highest requesting stage k stalls
// stages 0..k+1 (clamped to the last stage) so one bubble is inserted.
module stall_thermo
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE
) (
    input  logic [NSTAGE-1:0] i_stop_req,
    output logic [NSTAGE-1:0] o_stall
);

    logic w_acc;

    // stall[s] is the OR of every request at index s-1 or above.
    always_comb begin
        o_stall = '0;
        w_acc   = (i_stop_req[NSTAGE-1] == Stop);
        for (int s = NSTAGE - 1; s >= 1; s--) begin
            w_acc      = w_acc | (i_stop_req[s-1] == Stop);
            o_stall[s] = w_acc;
        end
        o_stall[0] = w_acc;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: thermometer stall vector, stretched flush with held
// target PC, stall watchdog and stall-cycle performance counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE     = DEF_NSTAGE,
    parameter int FLUSH_HOLD = DEF_FLUSH_HOLD,
    parameter int PC_W       = DEF_PC_W,
    parameter int WDOG_W     = DEF_WDOG_W,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic       cpu_clk_75M,
    input  logic       cpu_rst_n,
    pipe_ctrl_if.slave bus
);

    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLUSH_HOLD - 1);
    localparam logic [WDOG_W-1:0] RUN_LIMIT = WDOG_W'(WDOG_LIMIT);

    logic [NSTAGE-1:0]      w_stall_raw;
    logic                   w_rst_active;
    logic                   w_flush;
    logic                   w_stall_any;
    logic [WDOG_W-1:0]      w_run_next;

    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [PC_W-1:0]        r_pc_q;
    logic [WDOG_W-1:0]      r_run_cnt;
    logic                   r_wdog_timeout;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    stall_thermo #(.NSTAGE(NSTAGE)) u_thermo (
        .i_stop_req (bus.stop_req),
        .o_stall    (w_stall_raw)
    );

    // Outputs are forced low during reset so an aborted flush leaves no trace.
    assign w_rst_active     = (cpu_rst_n == RstEnable);
    assign w_flush          = !w_rst_active && (bus.flush_req || (r_hold_cnt != '0));
    assign w_stall_any      = |bus.stall;
    assign bus.flush_o      = w_flush;
    assign bus.stall        = (w_rst_active || w_flush) ? '0 : w_stall_raw;
    assign bus.flush_pc_o   = w_rst_active ? '0 : (bus.flush_req ? bus.flush_pc : r_pc_q);
    assign bus.wdog_timeout = r_wdog_timeout;
    assign bus.stall_cycles = r_stall_cycles;

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_hold_cnt <= '0;
            r_pc_q     <= '0;
        end else if (bus.flush_req) begin
            r_hold_cnt <= HOLD_INIT;
            r_pc_q     <= bus.flush_pc;
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end
    end

    always_comb begin
        w_run_next = r_run_cnt;
        if (!w_stall_any || w_flush) begin
            w_run_next = '0;
        end else if (r_run_cnt != RUN_LIMIT) begin
            w_run_next = r_run_cnt + WDOG_W'(1);
        end
    end

    // A clear in the same cycle as the trip wins over setting the flag.
    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_run_cnt      <= '0;
            r_wdog_timeout <= 1'b0;
        end else if (bus.wdog_clr) begin
            r_run_cnt      <= '0;
            r_wdog_timeout <= 1'b0;
        end else begin
            r_run_cnt <= w_run_next;
            if (w_run_next == RUN_LIMIT) begin
                r_wdog_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall_any) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule
